// File: rtl/imem_loadable.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_loadable                                                              |
// | Runtime-loadable instruction memory: zero-clear sequencer, byte-serial     |
// | program load port and a registered fetch path with flush/stall.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module imem_loadable #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc,
  input  logic             branch,
  input  logic             stall,
  output logic [WIDTH-1:0] instruction,
  output logic             valid,
  output logic             fault,
  input  logic             ld_start,
  input  logic             ld_valid,
  input  logic [7:0]       ld_data,
  output logic             ld_ready,
  input  logic             ld_done,
  output logic             busy
);

  localparam int BYTES = WIDTH / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [BW-1:0] LAST_LANE = BW'(BYTES - 1);
  localparam logic [31:0]   DEPTH_PC  = 32'(DEPTH);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cptr_q, cptr_d;
  logic [AW:0]      wptr_q, wptr_d;
  logic [BW-1:0]    bidx_q, bidx_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] instr_q;
  logic             valid_q, fault_q;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             accept;
  logic [WIDTH-1:0] asm_fill;

  assign busy        = (state_q != ST_RUN);
  assign ld_ready    = (state_q == ST_LOAD) && (wptr_q < DEPTH_W);
  assign accept      = ld_valid && ld_ready;
  assign instruction = instr_q;
  assign valid       = valid_q;
  assign fault       = fault_q;

  // Assembly word including this cycle's byte; unfilled lanes stay zero.
  always_comb begin
    asm_fill = asm_q;
    if (accept) asm_fill[{bidx_q, 3'b000} +: 8] = ld_data;
  end

  always_comb begin
    state_d   = state_q;
    cptr_d    = cptr_q;
    wptr_d    = wptr_q;
    bidx_d    = bidx_q;
    asm_d     = asm_q;
    mem_we    = 1'b0;
    mem_waddr = cptr_q;
    mem_wdata = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        cptr_d = cptr_q + 1'b1;
        if (cptr_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ld_start) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
          bidx_d  = '0;
          asm_d   = '0;
        end
      end
      ST_LOAD: begin
        mem_waddr = wptr_q[AW-1:0];
        mem_wdata = asm_fill;
        if (ld_done) begin
          mem_we  = accept || (bidx_q != '0);
          state_d = ST_RUN;
          wptr_d  = '0;
          bidx_d  = '0;
          asm_d   = '0;
        end else if (ld_start) begin
          wptr_d = '0;
          bidx_d = '0;
          asm_d  = '0;
        end else if (accept) begin
          if (bidx_q == LAST_LANE) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + 1'b1;
            bidx_d = '0;
            asm_d  = '0;
          end else begin
            bidx_d = bidx_q + 1'b1;
            asm_d  = asm_fill;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cptr_q  <= '0;
      wptr_q  <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      cptr_q  <= cptr_d;
      wptr_q  <= wptr_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Out-of-range check uses the full pc; only the low bits address the array.
  always_ff @(posedge clk) begin
    if (rst || (state_q != ST_RUN) || branch) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (!stall) begin
      if (pc >= DEPTH_PC) begin
        instr_q <= '0;
        valid_q <= 1'b0;
        fault_q <= 1'b1;
      end else begin
        instr_q <= mem_q[pc[AW-1:0]];
        valid_q <= 1'b1;
        fault_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loadable.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_imem_loadable                                                           |
// | Directed + randomized bench for imem_loadable against a word-array model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_imem_loadable;

  localparam int DEPTH = 256;
  localparam int WIDTH = 32;

  typedef logic [7:0] bq_t[$];

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      pc = '0;
  logic             branch = 1'b0;
  logic             stall = 1'b0;
  logic [WIDTH-1:0] instruction;
  logic             valid;
  logic             fault;
  logic             ld_start = 1'b0;
  logic             ld_valid = 1'b0;
  logic [7:0]       ld_data = '0;
  logic             ld_ready;
  logic             ld_done = 1'b0;
  logic             busy;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] model [DEPTH];

  imem_loadable #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .branch(branch), .stall(stall),
    .instruction(instruction), .valid(valid), .fault(fault),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Words touched by a load from word 0: little-endian bytes, missing lanes zero.
  task automatic apply_model(input bq_t b);
    logic [31:0] v;
    for (int w = 0; (w * 4 < b.size()) && (w < DEPTH); w++) begin
      v = '0;
      for (int l = 0; l < 4; l++)
        if (w * 4 + l < b.size()) v[8*l +: 8] = b[w*4+l];
      model[w] = v;
    end
  endtask

  task automatic do_reset();
    int cnt;
    rst = 1'b1; ld_start = 0; ld_valid = 0; ld_done = 0; branch = 0; stall = 0; pc = '0;
    tick(); tick();
    check("rst.instruction", instruction, 0);
    check("rst.valid", valid, 0);
    check("rst.fault", fault, 0);
    check("rst.ld_ready", ld_ready, 0);
    check("rst.busy", busy, 1);
    rst = 1'b0;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (busy && cnt < 1000);
    check("clear_cycles", cnt, DEPTH);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic fetch(input logic [31:0] a);
    logic f;
    logic [31:0] e;
    pc = a; branch = 0; stall = 0;
    tick();
    f = (a >= DEPTH);
    e = f ? 32'h0 : model[a % DEPTH];
    check($sformatf("fetch[%0h].instruction", a), instruction, e);
    check($sformatf("fetch[%0h].valid", a), valid, !f);
    check($sformatf("fetch[%0h].fault", a), fault, f);
  endtask

  // The fetch issued alongside ld_start must still complete.
  task automatic begin_load(input logic [31:0] a);
    pc = a; branch = 0; stall = 0; ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("ldstart_fetch.instruction", instruction, model[a]);
    check("ldstart_fetch.valid", valid, 1);
    check("load.busy", busy, 1);
  endtask

  task automatic push(input logic [7:0] b, input logic exp_rdy);
    ld_valid = 1'b1; ld_data = b;
    check("load.ld_ready", ld_ready, exp_rdy);
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic push_done(input logic [7:0] b);
    ld_valid = 1'b1; ld_data = b; ld_done = 1'b1;
    tick();
    ld_valid = 1'b0; ld_done = 1'b0;
    check("done_byte.busy", busy, 0);
  endtask

  task automatic end_load();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    check("end_load.busy", busy, 0);
    check("end_load.valid", valid, 0);
  endtask

  initial begin
    bq_t q;
    int n;

    do_reset();
    fetch(5);

    q = {8'h55, 8'h55, 8'h41, 8'h08, 8'h0E, 8'h00, 8'h46, 8'h80};
    begin_load(0);
    foreach (q[i]) push(q[i], 1'b1);
    end_load();
    apply_model(q);
    fetch(0);
    check("word0_const", instruction, 32'h08415555);
    fetch(1);
    check("word1_const", instruction, 32'h8046000E);

    q = {8'h03, 8'h00};
    begin_load(1);
    foreach (q[i]) push(q[i], 1'b1);
    end_load();
    apply_model(q);
    fetch(0);
    check("partial_const", instruction, 32'h00000003);
    fetch(1);

    q = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12};
    begin_load(0);
    for (int i = 0; i < 4; i++) push(q[i], 1'b1);
    push_done(q[4]);
    apply_model(q);
    fetch(0);
    fetch(1);

    for (int r = 0; r < 5; r++) begin
      n = (r == 4) ? 40 : $urandom_range(1, 40);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      begin_load(32'($urandom_range(0, DEPTH - 1)));
      for (int i = 0; i < n - 1; i++) push(q[i], 1'b1);
      if ($urandom_range(0, 1) == 1) push_done(q[n-1]);
      else begin
        push(q[n-1], 1'b1);
        end_load();
      end
      apply_model(q);
      for (int i = 0; i < 6; i++) fetch(32'($urandom_range(0, 15)));
      fetch($urandom | 32'h100);
    end

    fetch(9);
    stall = 1'b1; pc = 32'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.instruction", instruction, model[9]);
      check("stall.valid", valid, 1);
    end
    branch = 1'b1;
    tick();
    check("branch_stall.instruction", instruction, 0);
    check("branch_stall.valid", valid, 0);
    branch = 1'b0; stall = 1'b0;

    fetch(32'd256);
    fetch(32'h8000_0000);
    fetch(32'd255);

    q = {};
    for (int i = 0; i < DEPTH * 4; i++) q.push_back(8'($urandom));
    begin_load(0);
    foreach (q[i]) push(q[i], 1'b1);
    push(8'hEE, 1'b0);
    end_load();
    apply_model(q);
    fetch(0);
    fetch(1);
    fetch(128);
    fetch(255);

    q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    begin_load(0);
    foreach (q[i]) push(q[i], 1'b1);
    end_load();
    apply_model(q);
    begin_load(0);
    q = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    foreach (q[i]) push(q[i], 1'b1);
    model[0] = 32'hA4A3A2A1;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("restart.busy", busy, 1);
    check("restart.ld_ready", ld_ready, 1);
    push(8'hC7, 1'b1);
    end_load();
    q = {8'hC7};
    apply_model(q);
    fetch(0);
    check("restart_const", instruction, 32'h000000C7);
    fetch(1);
    check("restart_keep_const", instruction, 32'h88776655);

    begin_load(2);
    for (int i = 0; i < 6; i++) push(8'($urandom | 1), 1'b1);
    do_reset();
    for (int a = 0; a < DEPTH; a++) fetch(a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, runtime-loadable instruction memory for the H2BP core, replacing the hard-coded fetch ROM. It serves registered fetches at the core's word-indexed `pc`, with branch flush and stall hold. A byte-serial load port lets a host write a program into the array before the core runs. After reset, an internal sequencer clears the array to zeros, so every unwritten word reads back as a NOP.

## Interface
Parameters:
- `DEPTH`, 256, number of instruction words; power of two, ≥ 2
- `WIDTH`, 32, instruction width in bits; multiple of 8
- `BYTES`, WIDTH/8 (derived, not overridable), bytes per word

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `pc`  in  32  word index of the instruction to fetch
- `branch`  in  1  flush: next `instruction` is NOP
- `stall`  in  1  hold `instruction`/`valid`/`fault` unchanged
- `instruction`  out  WIDTH  fetched word (registered)
- `valid`  out  1  `instruction` is a real fetch result
- `fault`  out  1  fetch address was out of range (`pc` ≥ DEPTH)
- `ld_start`  in  1  enter LOAD and reset load pointer to word 0, byte 0
- `ld_valid`  in  1  `ld_data` byte offered
- `ld_data`  in  8  load byte
- `ld_ready`  out  1  load byte accepted when `ld_valid && ld_ready`
- `ld_done`  in  1  end of load; return to RUN
- `busy`  out  1  state is CLEAR or LOAD

## Operation
- States are CLEAR, RUN and LOAD.
  - `rst` moves the block to CLEAR from any state, mid-load included, and discards any partial word.
- CLEAR:
  - Clear pointer starts at 0 and writes zero to one word per cycle.
  - After writing word DEPTH-1, moves to RUN. CLEAR lasts exactly DEPTH cycles after `rst` deasserts.
  - `ld_*` inputs and `pc` are ignored.
- RUN:
  - Normal fetch runs unless `ld_start`=1, which moves the block to LOAD next cycle.
  - The fetch launched in that same cycle still completes.
- LOAD:
  - `ld_ready`=1 while word pointer < DEPTH.
  - Each accepted byte goes to lane `bidx` of the assembly register, little-endian: byte k lands in bits [8k+7:8k].
  - When byte BYTES-1 is accepted, the full word is written at `wptr`, `wptr` increments and `bidx` returns to 0.
  - When `wptr` = DEPTH, `ld_ready`=0 and further bytes are not accepted.
  - `ld_done`: any partial word is written, with unfilled lanes zero, then the block moves to RUN.
    - If `ld_valid && ld_ready` occurs in the same cycle, that byte is included first.
  - `ld_start` while in LOAD resets the pointers and discards the partial word; already-written words are kept.
  - `ld_start` and `ld_done` together: `ld_done` wins.
- Fetch-register update priority, evaluated each cycle:
  1. `rst`: `instruction`=0, `valid`=0, `fault`=0.
  2. State CLEAR or LOAD: all three = 0.
  3. `branch`: all three = 0.
  4. `stall`: hold all three.
  5. `pc` ≥ DEPTH: `instruction`=0, `valid`=0, `fault`=1.
  6. Otherwise: `instruction`=mem[pc], `valid`=1, `fault`=0.
- The address comparison uses all 32 bits of `pc`; there is no wrap-around. Only the low log2(DEPTH) bits index the array.
- `busy` is combinational from state.
- `ld_ready` is combinational from state and `wptr`.

## Timing
- Reset values: `instruction`=0, `valid`=0, `fault`=0, `ld_ready`=0, `busy`=1 (CLEAR).
- Fetch latency is 1 cycle: `pc` presented at edge N appears on `instruction` after edge N.
- Read-during-write to the same word cannot occur, since fetch is idle outside RUN.
- A word written in LOAD is readable on the first RUN fetch.
- RUN is entered on the edge after the `ld_done` cycle; the first fetch result is valid one cycle later.
- `branch` and `stall` together: `branch` wins, giving a NOP.
- Throughput is one byte per cycle when `ld_valid` is held high; BYTES cycles per word.

## Test plan
- Reset, then idle DEPTH=256 cycles → `busy` falls exactly 256 cycles after `rst` deasserts; fetch of `pc`=5 returns 0 with `valid`=1.
- Load bytes 0x55,0x55,0x41,0x08 to word 0 and 0x0E,0x00,0x46,0x80 to word 1, then `ld_done`. Fetch `pc`=0, then `pc`=1 → `instruction`=0x08415555, then 0x8046000E, each 1 cycle after its `pc`.
- Load 0x03,0x00 then assert `ld_done` (partial word) → word 0 reads 0x00000003; word 1 keeps its prior value.
- Fetch `pc`=9 with `stall`=1 for 3 cycles, then `branch` with `stall`: output held 3 cycles, then `instruction`=0 and `valid`=0.
- `pc`=256 and `pc`=0x80000000 with DEPTH=256 → `instruction`=0, `fault`=1, `valid`=0; `pc`=255 → `fault`=0.
- Three checks around load/reset boundaries:
  - Fill all 256 words, then offer a further byte → `ld_ready`=0 and the byte is not accepted.
  - `rst` mid-load → CLEAR, and all words read 0 afterwards.
  - `ld_start` mid-word → the partial word is dropped and the next byte goes to word 0, lane 0.
